// File: rtl/flash_seq_if.sv
// Host command/response channel of the flash sequencer.
interface flash_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [18:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/flash_seq.sv
// JEDEC command sequencer for an AM29F040-class parallel flash: read, program,
// sector/chip erase with toggle-bit polling, DQ5 error and poll timeout.
module flash_seq #(
  parameter int unsigned T_ACC = 4,
  parameter int unsigned T_WP  = 3,
  parameter int unsigned TO_W  = 20
) (
  input  logic        clk_fpga,
  input  logic        rst,
  flash_seq_if.slave  host,
  output logic [18:0] fl_a,
  output logic [7:0]  fl_d_out,
  output logic        fl_d_oe,
  input  logic [7:0]  fl_d_in,
  output logic        fl_ce_n,
  output logic        fl_oe_n,
  output logic        fl_we_n
);
  localparam int unsigned CMAX = (T_ACC > T_WP + 2) ? T_ACC : T_WP + 2;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_ACC  = CW'(T_ACC);
  localparam logic [CW-1:0] C_ACC1 = CW'(T_ACC - 1);
  localparam logic [CW-1:0] C_WP   = CW'(T_WP);
  localparam logic [CW-1:0] C_WG   = CW'(T_WP + 2);

  typedef enum logic [2:0] {RSTCMD, IDLE, READ, WSEQ, POLL, ABORT, RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_PROG, OP_SERASE, OP_CERASE} op_t;

  state_t         state, n_state;
  op_t            op, n_op;
  logic [CW-1:0]  cnt, n_cnt;
  logic           act, n_act, wr, n_wr;
  logic [2:0]     step, n_step;
  logic [18:0]    addr, n_addr, n_a;
  logic [7:0]     wdata, n_wdata, n_d, rdata, n_rdata;
  logic           first, n_first, retry, n_retry, prev6, n_prev6, err, n_err;
  logic [TO_W-1:0] pc, n_pc;
  logic           ready_q, rvalid_q;
  logic           n_ce_n, n_oe_n, n_we_n, n_d_oe;
  logic           start_w, start_r, last_w, last_r;
  logic [26:0]    w_word;

  assign host.cmd_ready  = ready_q;
  assign host.resp_valid = rvalid_q;
  assign host.resp_rdata = rdata;
  assign host.resp_err   = err;

  function automatic logic [26:0] wword(input op_t o, input logic [2:0] s,
                                        input logic [18:0] a, input logic [7:0] d);
    logic [26:0] w;
    case (s)
      3'd0, 3'd3: w = {19'h00555, 8'hAA};
      3'd1, 3'd4: w = {19'h002AA, 8'h55};
      3'd2:       w = {19'h00555, (o == OP_PROG) ? 8'hA0 : 8'h80};
      default:    w = (o == OP_CERASE) ? {19'h00555, 8'h10} : {a[18:16], 16'h0000, 8'h30};
    endcase
    if (o == OP_PROG && s == 3'd3) w = {a, d};
    return w;
  endfunction

  // A bus op is a phase counter (cnt) under act; ops chain back-to-back by
  // restarting cnt on the edge that ends the previous one.
  always_comb begin
    n_state = state;  n_op = op;  n_cnt = cnt;  n_act = act;  n_wr = wr;
    n_step = step;  n_addr = addr;  n_wdata = wdata;  n_rdata = rdata;
    n_first = first;  n_retry = retry;  n_prev6 = prev6;  n_pc = pc;  n_err = err;
    n_a = fl_a;  n_d = fl_d_out;
    start_w = 1'b0;  start_r = 1'b0;  w_word = '0;
    last_w = act && wr && (cnt == C_WG);
    last_r = act && !wr && (cnt == C_ACC);
    if (act && !wr && cnt == C_ACC1) n_rdata = fl_d_in;
    if (act) n_cnt = cnt + 1'b1;

    case (state)
      RSTCMD: begin
        if (!act) begin
          start_w = 1'b1;  w_word = {19'h0, 8'hF0};
        end else if (last_w) begin
          n_act = 1'b0;  n_state = IDLE;
        end
      end
      IDLE: begin
        if (host.cmd_valid && ready_q) begin
          n_op = op_t'(host.cmd_op);  n_addr = host.cmd_addr;  n_wdata = host.cmd_wdata;
          n_step = '0;
          n_state = (op_t'(host.cmd_op) == OP_READ) ? READ : WSEQ;
        end
      end
      READ: begin
        if (!act) start_r = 1'b1;
        else if (last_r) begin
          n_act = 1'b0;  n_err = 1'b0;  n_state = RESP;
        end
      end
      WSEQ: begin
        if (!act) begin
          start_w = 1'b1;  w_word = wword(op, step, addr, wdata);
        end else if (last_w) begin
          if (step == ((op == OP_PROG) ? 3'd3 : 3'd5)) begin
            n_state = POLL;  start_r = 1'b1;
            n_first = 1'b1;  n_retry = 1'b0;  n_pc = '0;
          end else begin
            n_step = step + 3'd1;  start_w = 1'b1;
            w_word = wword(op, step + 3'd1, addr, wdata);
          end
        end
      end
      POLL: begin
        if (last_r) begin
          n_pc = pc + 1'b1;  n_prev6 = rdata[6];
          if (first) begin
            n_first = 1'b0;  start_r = 1'b1;
          end else if (rdata[6] == prev6) begin
            n_act = 1'b0;  n_state = RESP;
            n_err = (op == OP_PROG) ? (rdata != wdata) : (rdata != 8'hFF);
          end else if (retry || n_pc == '1) begin
            n_state = ABORT;  start_w = 1'b1;  w_word = {19'h0, 8'hF0};
          end else begin
            n_retry = rdata[5];  start_r = 1'b1;
          end
        end
      end
      ABORT: begin
        if (last_w) begin
          n_act = 1'b0;  n_err = 1'b1;  n_state = RESP;
        end
      end
      RESP:    n_state = IDLE;
      default: n_state = RSTCMD;
    endcase

    if (start_w) begin
      n_act = 1'b1;  n_cnt = '0;  n_wr = 1'b1;  n_a = w_word[26:8];  n_d = w_word[7:0];
    end
    if (start_r) begin
      n_act = 1'b1;  n_cnt = '0;  n_wr = 1'b0;  n_a = addr;
    end
    n_ce_n = !n_act || (n_wr ? (n_cnt == C_WG) : (n_cnt == C_ACC));
    n_oe_n = !(n_act && !n_wr && n_cnt < C_ACC);
    n_we_n = !(n_act && n_wr && n_cnt != '0 && n_cnt <= C_WP);
    n_d_oe = n_act && n_wr && n_cnt < C_WG;
  end

  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      state <= RSTCMD;  op <= OP_READ;  cnt <= '0;  act <= 1'b0;  wr <= 1'b0;
      step <= '0;  addr <= '0;  wdata <= '0;  rdata <= '0;
      first <= 1'b0;  retry <= 1'b0;  prev6 <= 1'b0;  pc <= '0;  err <= 1'b0;
      fl_a <= '0;  fl_d_out <= '0;  fl_d_oe <= 1'b0;
      fl_ce_n <= 1'b1;  fl_oe_n <= 1'b1;  fl_we_n <= 1'b1;
      ready_q <= 1'b0;  rvalid_q <= 1'b0;
    end else begin
      state <= n_state;  op <= n_op;  cnt <= n_cnt;  act <= n_act;  wr <= n_wr;
      step <= n_step;  addr <= n_addr;  wdata <= n_wdata;  rdata <= n_rdata;
      first <= n_first;  retry <= n_retry;  prev6 <= n_prev6;  pc <= n_pc;  err <= n_err;
      fl_a <= n_a;  fl_d_out <= n_d;  fl_d_oe <= n_d_oe;
      fl_ce_n <= n_ce_n;  fl_oe_n <= n_oe_n;  fl_we_n <= n_we_n;
      ready_q <= (n_state == IDLE);
      rvalid_q <= (n_state == RESP);
    end
  end
endmodule
